// File: rtl/rv_mem_resp_pkg.sv
// Shared memory-responder definitions: FSM states, memrw encodings and
// the address legality rule used by the responder.
package rv_mem_resp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } mem_state_e;

   localparam logic MEM_READ  = 1'b0;
   localparam logic MEM_WRITE = 1'b1;

   // A byte address is legal when it is word aligned and its word index
   // falls inside the storage array.
   function automatic logic addr_legal(input logic [31:0] a, input int unsigned depth);
      return (a[1:0] == 2'b00) && ({2'b00, a[31:2]} < depth);
   endfunction

endpackage

// File: rtl/rv_mem_resp_array.sv
// Word storage for the memory responder: DEPTH_WORDS x 32 bits,
// synchronous write, combinational read, contents never reset.
module rv_mem_array
   import rv_mem_resp_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256,
   localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   // Write port: one word per clock when enabled.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/rv_mem_resp.sv
// Memory responder: accepts a single read/write request in IDLE, waits
// WAIT_CYCLES, then pulses ready for one cycle with err for illegal
// addresses. Reads are registered into rdata on entry to RESP; writes
// commit at the edge that ends RESP.
module rv_mem_resp
   import rv_mem_resp_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        memrw,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        err
);

   localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   mem_state_e  state_q, state_d;
   logic [3:0]  cnt_q;
   logic        cap_rw_q;
   logic [31:0] cap_addr_q;
   logic [31:0] cap_wdata_q;
   logic [31:0] rdata_q;

   logic        eff_rw;
   logic [31:0] eff_addr;
   logic        eff_legal;
   logic        cap_legal;
   logic        enter_resp;
   logic        mem_we;
   logic [31:0] mem_rdata;

   // With WAIT_CYCLES=0 the edge entering RESP is also the capture edge,
   // so the read source is the live inputs rather than the capture regs.
   assign eff_rw     = (state_q == IDLE) ? memrw : cap_rw_q;
   assign eff_addr   = (state_q == IDLE) ? addr  : cap_addr_q;
   assign eff_legal  = addr_legal(eff_addr, DEPTH_WORDS);
   assign cap_legal  = addr_legal(cap_addr_q, DEPTH_WORDS);
   assign enter_resp = (state_d == RESP) && (state_q != RESP);
   assign mem_we     = (state_q == RESP) && (cap_rw_q == MEM_WRITE) && cap_legal;

   assign ready = (state_q == RESP);
   assign err   = (state_q == RESP) && !cap_legal;
   assign rdata = rdata_q;

   rv_mem_array #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_array (
      .clk   (clk),
      .we    (mem_we),
      .waddr (cap_addr_q[AW+1:2]),
      .wdata (cap_wdata_q),
      .raddr (eff_addr[AW+1:2]),
      .rdata (mem_rdata)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: accept in IDLE, count down in WAIT, single-cycle RESP.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req) state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
         WAIT:    if (cnt_q == 4'd0) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Wait-state counter: loaded on entry to WAIT, decremented while waiting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if ((state_q == IDLE) && (state_d == WAIT)) begin
         cnt_q <= WAIT_LOAD;
      end else if ((state_q == WAIT) && (cnt_q != 4'd0)) begin
         cnt_q <= cnt_q - 4'd1;
      end
   end

   // Request capture: only in IDLE, so the request is frozen while busy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_rw_q    <= MEM_READ;
         cap_addr_q  <= '0;
         cap_wdata_q <= '0;
      end else if ((state_q == IDLE) && req) begin
         cap_rw_q    <= memrw;
         cap_addr_q  <= addr;
         cap_wdata_q <= wdata;
      end
   end

   // Read data: cleared on an illegal request, loaded on a legal read,
   // otherwise held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (enter_resp) begin
         if (!eff_legal) begin
            rdata_q <= '0;
         end else if (eff_rw == MEM_READ) begin
            rdata_q <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_rv_mem_resp.sv
// Self-checking bench for rv_mem_resp: one instance with two wait states,
// one with none, both checked against a word-array reference model.
module tb_rv_mem_resp;

   localparam int unsigned D2 = 64;
   localparam int unsigned D0 = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req2 = 1'b0, req0 = 1'b0;
   logic        memrw = 1'b0;
   logic [31:0] addr = '0, wdata = '0;
   logic [31:0] rdata2, rdata0;
   logic        ready2, ready0, err2, err0;

   int unsigned checks = 0;
   int unsigned errors = 0;

   logic [31:0] m2 [D2];
   logic [31:0] m0 [D0];
   logic [31:0] prev2 = '0, prev0 = '0;

   always #5 clk = ~clk;

   rv_mem_resp #(.DEPTH_WORDS(D2), .WAIT_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .req(req2), .memrw(memrw), .addr(addr),
      .wdata(wdata), .rdata(rdata2), .ready(ready2), .err(err2)
   );

   rv_mem_resp #(.DEPTH_WORDS(D0), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .req(req0), .memrw(memrw), .addr(addr),
      .wdata(wdata), .rdata(rdata0), .ready(ready0), .err(err0)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic set_req(input bit sel, input logic v);
      if (sel) req0 = v; else req2 = v;
   endtask

   // One complete transaction; called #1 after a rising edge with the DUT idle.
   task automatic txn(input bit sel, input logic rw, input logic [31:0] a, input logic [31:0] d);
      int unsigned n, depth, w, idx;
      bit          legal;
      logic [31:0] exp_rd;
      depth = sel ? D0 : D2;
      w     = sel ? 0 : 2;
      legal = (a[1:0] == 2'b00) && ({2'b00, a[31:2]} < depth);
      idx   = {2'b00, a[31:2]};
      if (!legal)  exp_rd = '0;
      else if (rw) exp_rd = sel ? prev0 : prev2;
      else         exp_rd = sel ? m0[idx] : m2[idx];

      memrw = rw; addr = a; wdata = d; set_req(sel, 1'b1);
      @(posedge clk); #1;
      n = 1;
      // Busy-time junk must not disturb the captured request.
      memrw = 1'($urandom); addr = $urandom; wdata = $urandom; set_req(sel, 1'($urandom));
      while (!(sel ? ready0 : ready2) && n <= 20) begin
         chk("err_low_while_busy", sel ? err0 : err2, 0);
         @(posedge clk); #1;
         n++;
      end
      chk("latency", n, w + 1);
      chk("err", sel ? err0 : err2, {31'd0, !legal});
      chk("rdata", sel ? rdata0 : rdata2, exp_rd);
      @(posedge clk); #1;
      set_req(sel, 1'b0);
      chk("ready_one_cycle", sel ? ready0 : ready2, 0);
      chk("err_after_resp", sel ? err0 : err2, 0);
      chk("rdata_held", sel ? rdata0 : rdata2, exp_rd);
      if (legal && rw) begin
         if (sel) m0[idx] = d; else m2[idx] = d;
      end
      if (sel) prev0 = exp_rd; else prev2 = exp_rd;
   endtask

   function automatic logic [31:0] rand_addr(input bit sel);
      int unsigned depth, k, idx;
      depth = sel ? D0 : D2;
      k     = $urandom_range(0, 9);
      idx   = $urandom_range(0, depth - 1);
      if (k < 7)       return idx << 2;
      else if (k == 7) return (idx << 2) | $urandom_range(1, 3);
      else if (k == 8) return (depth + $urandom_range(0, 5)) << 2;
      else             return $urandom | 32'h8000_0000;
   endfunction

   initial begin
      int unsigned pulses, wide;
      logic        last;
      logic [31:0] a, d;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready2", ready2, 0);
      chk("rst_err2", err2, 0);
      chk("rst_rdata2", rdata2, 0);
      chk("rst_ready0", ready0, 0);
      chk("rst_err0", err0, 0);
      chk("rst_rdata0", rdata0, 0);
      rst = 1'b0;

      // Fill both arrays so every model word is known.
      for (int unsigned i = 0; i < D2; i++) txn(1'b0, 1'b1, i << 2, $urandom);
      for (int unsigned i = 0; i < D0; i++) txn(1'b1, 1'b1, i << 2, $urandom);

      // Directed cases.
      txn(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
      txn(1'b0, 1'b0, 32'h10, 32'h0);
      chk("deadbeef", rdata2, 32'hDEAD_BEEF);
      txn(1'b0, 1'b0, 32'h12, 32'h0);
      txn(1'b0, 1'b0, 32'h10, 32'h0);
      txn(1'b0, 1'b1, 4 * D2, 32'h1234_5678);
      txn(1'b0, 1'b0, 32'h0, 32'h0);
      txn(1'b0, 1'b0, 4 * (D2 - 1), 32'h0);
      txn(1'b1, 1'b0, 32'h8, 32'h0);
      txn(1'b1, 1'b1, 4 * D0, 32'hFFFF_FFFF);
      txn(1'b1, 1'b0, 4 * (D0 - 1), 32'h0);

      // Read-after-write on the same word.
      for (int unsigned i = 0; i < 6; i++) begin
         bit s;
         s = 1'(i);
         a = rand_addr(s) & 32'h0000_00FC;
         if (s) a = a & 32'h3C;
         d = $urandom;
         txn(s, 1'b1, a, d);
         txn(s, 1'b0, a, 32'h0);
      end

      // Random mix of reads, writes and illegal addresses.
      for (int unsigned i = 0; i < 80; i++) begin
         bit s;
         s = ($urandom_range(0, 3) == 0);
         txn(s, 1'($urandom), rand_addr(s), $urandom);
      end

      // req held high for 12 cycles.
      pulses = 0; wide = 0; last = 1'b0;
      memrw = 1'b0; addr = 32'h0; req2 = 1'b1;
      for (int unsigned i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (ready2 === 1'b1) begin
            pulses++;
            if (last) wide++;
            chk("hold_rdata", rdata2, m2[0]);
         end
         last = (ready2 === 1'b1);
      end
      req2 = 1'b0;
      chk("hold_pulses", pulses, 3);
      chk("hold_wide", wide, 0);
      prev2 = m2[0];
      @(posedge clk); #1;

      // Reset during WAIT of a write to 0x20.
      memrw = 1'b1; addr = 32'h20; wdata = ~m2[8]; req2 = 1'b1;
      @(posedge clk); #1;
      req2 = 1'b0;
      chk("pre_rst_ready", ready2, 0);
      rst = 1'b1;
      #1;
      chk("mid_rst_ready", ready2, 0);
      chk("mid_rst_err", err2, 0);
      chk("mid_rst_rdata2", rdata2, 0);
      chk("mid_rst_rdata0", rdata0, 0);
      for (int unsigned i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("in_rst_ready", ready2, 0);
      end
      rst = 1'b0;
      prev2 = '0; prev0 = '0;
      txn(1'b0, 1'b0, 32'h20, 32'h0);
      txn(1'b1, 1'b0, 32'h4, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rv_mem_resp.md
RV_MEM_RESP -- requirements
Module: rv_mem_resp

Interface
REQ-001 The block SHALL have the parameter DEPTH_WORDS, default 256, meaning the number of 32-bit storage words.
REQ-002 The block SHALL have the parameter WAIT_CYCLES, default 2, meaning the wait states between request acceptance and response (range 0..15).
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have the port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have the port req, input, 1 bit: the initiator request strobe.
REQ-006 The block SHALL have the port memrw, input, 1 bit: 1 = write, 0 = read (same encoding as the control plane's memrw).
REQ-007 The block SHALL have the port addr, input, 32 bits: the byte address.
REQ-008 The block SHALL have the port wdata, input, 32 bits: the write data.
REQ-009 The block SHALL have the port rdata, output, 32 bits: the read data.
REQ-010 The block SHALL have the port ready, output, 1 bit: a one-cycle completion pulse.
REQ-011 The block SHALL have the port err, output, 1 bit: an error flag, valid only while ready=1.

Function
REQ-012 FSM states SHALL be IDLE, WAIT, RESP.
REQ-013 IDLE: req=1 SHALL capture memrw, addr and wdata into internal registers; next = WAIT if WAIT_CYCLES>0, else RESP.
REQ-014 On entry to WAIT the counter SHALL load WAIT_CYCLES-1; it decrements each cycle; on count 0 next = RESP.
REQ-015 RESP SHALL last exactly one cycle with ready=1; next = IDLE.
REQ-016 Latency SHALL be WAIT_CYCLES+1 cycles from the req-sampling edge to the ready-high cycle.
REQ-017 req SHALL be ignored in WAIT and RESP; the captured request SHALL NOT change while busy.
REQ-018 A request SHALL be accepted in the IDLE cycle immediately after RESP (back-to-back allowed).
REQ-019 Word index SHALL be addr[31:2]; a request SHALL be legal iff addr[1:0]==0 and the index is less than DEPTH_WORDS.
REQ-020 Legal write: the storage word SHALL update at the clock edge ending RESP; rdata SHALL remain unchanged.
REQ-021 Legal read: rdata SHALL be registered with the storage word at the edge entering RESP and held until the next read completes.
REQ-022 Illegal request: err=1 during RESP, no storage write, and rdata SHALL be set to 0.
REQ-023 err and ready SHALL be 0 in every state other than RESP.
REQ-024 A read of a word written by the immediately preceding request SHALL return the new data.

Reset
REQ-025 rst=1 SHALL asynchronously force state=IDLE, counter=0, rdata=0, ready=0, err=0 and clear the captured request registers.
REQ-026 Reset mid-operation SHALL abort the transaction with no storage write and no ready pulse.
REQ-027 Storage contents SHALL NOT be reset.
REQ-028 The first request SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-029 The state enum and the MEM_READ and MEM_WRITE encodings SHALL live in the shared params include/package used by the control plane.
REQ-030 Storage SHALL be a sub-module rv_mem_array (DEPTH_WORDS x 32, synchronous write, combinational read); the FSM, counter and error check SHALL live in rv_mem_resp.

Verification
REQ-031 With WAIT_CYCLES=2, write addr=0x10 wdata=0xDEADBEEF, then read 0x10 -> ready 3 cycles after each req; rdata=0xDEADBEEF; err=0.
REQ-032 Read addr=0x12 (misaligned) -> ready with err=1, rdata=0; a subsequent read of 0x10 still returns 0xDEADBEEF.
REQ-033 Write to addr=4*DEPTH_WORDS -> err=1; no storage word changes (read back words 0 and DEPTH_WORDS-1 unchanged).
REQ-034 Hold req=1 continuously for 12 cycles -> exactly 3 transactions, ready pulses one cycle wide, IDLE between them.
REQ-035 Assert rst during WAIT of a write to 0x20 -> no ready pulse, outputs 0, old contents of 0x20 preserved.
REQ-036 With WAIT_CYCLES=0, read -> ready on the cycle after req is sampled.
